// File: rtl/gb_bus_responder.sv
// gb_bus_responder: sm83 bus responder with HRAM, IE/IF, OAM DMA engine and external pass-through
module gb_bus_responder #(
   parameter int DMA_LEN = 160,
   parameter int IRQ_N = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      cpu_addr,
   input  logic [7:0]       cpu_wdata,
   input  logic             cpu_write,
   output logic [7:0]       cpu_rdata,
   output logic [15:0]      ext_addr,
   output logic [7:0]       ext_wdata,
   output logic             ext_write,
   input  logic [7:0]       ext_rdata,
   output logic [7:0]       oam_addr,
   output logic [7:0]       oam_wdata,
   output logic             oam_write,
   input  logic [IRQ_N-1:0] irq_req,
   input  logic [IRQ_N-1:0] irq_clr,
   output logic             irq_pending,
   output logic             dma_active
);
   localparam logic [7:0] LAST = 8'(DMA_LEN - 1);
   logic [7:0] hram [128];
   logic [7:0] ie, dma_reg, rd, rd_nxt, if_rd, src_hi, cnt, pipe_cnt;
   logic [IRQ_N-1:0] if_r, if_nxt;
   logic running, pipe_valid, src_ext;
   logic is_if, is_dma, is_ie, is_hram, is_ext;

   assign is_if = cpu_addr == 16'hFF0F;
   assign is_dma = cpu_addr == 16'hFF46;
   assign is_ie = cpu_addr == 16'hFFFF;
   assign is_hram = cpu_addr[15:7] == 9'h1FF && !is_ie;
   assign is_ext = !(is_if || is_dma || is_ie || is_hram);

   assign ext_addr = running ? {src_hi, cnt} : cpu_addr;
   assign ext_wdata = cpu_wdata;
   assign ext_write = cpu_write && is_ext && !running;
   assign cpu_rdata = src_ext ? ext_rdata : rd;
   assign oam_addr = pipe_cnt;
   assign oam_wdata = ext_rdata;
   assign oam_write = pipe_valid;
   assign dma_active = running || pipe_valid;
   assign irq_pending = |(ie[IRQ_N-1:0] & if_r);

   // IF next value (write, then clear, then request wins) and internal read mux
   always_comb begin
      if_rd = 8'hFF;
      if_rd[IRQ_N-1:0] = if_r;
      if_nxt = (cpu_write && is_if) ? cpu_wdata[IRQ_N-1:0] : if_r;
      if_nxt = (if_nxt & ~irq_clr) | irq_req;
      rd_nxt = is_hram ? hram[cpu_addr[6:0]] : is_ie ? ie : is_if ? if_rd : is_dma ? dma_reg : 8'hFF;
   end

   // HRAM storage, no reset
   always_ff @(posedge clk) begin
      if (cpu_write && is_hram) hram[cpu_addr[6:0]] <= cpu_wdata;
   end

   // Register file and one-cycle read pipeline; external reads during DMA return 0xFF
   always_ff @(posedge clk) begin
      if (reset) begin
         ie <= 8'h00;
         if_r <= '0;
         dma_reg <= 8'hFF;
         rd <= 8'hFF;
         src_ext <= 1'b0;
      end else begin
         if (cpu_write && is_ie) ie <= cpu_wdata;
         if (cpu_write && is_dma) dma_reg <= cpu_wdata;
         if_r <= if_nxt;
         rd <= rd_nxt;
         src_ext <= is_ext && !running;
      end
   end

   // DMA engine: issue {src_hi,cnt} each cycle, write previous read into OAM one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         running <= 1'b0;
         cnt <= 8'h00;
         src_hi <= 8'h00;
         pipe_valid <= 1'b0;
         pipe_cnt <= 8'h00;
      end else begin
         pipe_valid <= running;
         pipe_cnt <= cnt;
         if (cpu_write && is_dma) begin
            src_hi <= cpu_wdata;
            cnt <= 8'h00;
            running <= 1'b1;
         end else if (running) begin
            cnt <= (cnt == LAST) ? 8'h00 : cnt + 8'h01;
            running <= cnt != LAST;
         end
      end
   end
endmodule

// File: tb/tb_gb_bus_responder.sv
// tb_gb_bus_responder: randomized and directed checks of gb_bus_responder against a behavioural model
module tb_gb_bus_responder;
   logic clk = 0, reset = 1;
   logic [15:0] cpu_addr = 0;
   logic [7:0] cpu_wdata = 0;
   logic cpu_write = 0;
   logic [7:0] cpu_rdata;
   logic [15:0] ext_addr;
   logic [7:0] ext_wdata;
   logic ext_write;
   logic [7:0] ext_rdata = 0;
   logic [7:0] oam_addr, oam_wdata;
   logic oam_write;
   logic [4:0] irq_req = 0, irq_clr = 0;
   logic irq_pending, dma_active;
   int n_chk = 0, n_pass = 0;
   int act_n = 0;
   logic [15:0] oam_q[$];

   gb_bus_responder dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
      .cpu_rdata(cpu_rdata), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_write(ext_write),
      .ext_rdata(ext_rdata), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write(oam_write),
      .irq_req(irq_req), .irq_clr(irq_clr), .irq_pending(irq_pending), .dma_active(dma_active)
   );

   always #5 clk = ~clk;

   // External synchronous memory: data is the low address byte XOR 0xA5
   always @(posedge clk) ext_rdata <= ext_addr[7:0] ^ 8'hA5;

   // Log OAM writes and count DMA-active cycles
   always @(negedge clk) begin
      if (oam_write) oam_q.push_back({oam_addr, oam_wdata});
      if (dma_active) act_n++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic [4:0] rq = 0, input logic [4:0] cl = 0);
      @(posedge clk);
      #1;
      reset = 0;
      cpu_addr = a;
      cpu_wdata = d;
      cpu_write = w;
      irq_req = rq;
      irq_clr = cl;
      @(negedge clk);
   endtask

   logic [7:0] m_hram [128];
   logic [7:0] m_ie, exp_rd;
   logic [4:0] m_if;
   logic [15:0] exp_q[$];

   initial begin
      logic [15:0] a;
      logic [7:0] d;
      logic w, have_exp;
      logic [4:0] rq, cl;
      int kind;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rdata", cpu_rdata, 16'h00FF);
      check("reset_dma_active", dma_active, 0);
      check("reset_oam_write", oam_write, 0);
      check("reset_irq_pending", irq_pending, 0);
      drive(16'hFFFF, 0, 0);
      check("reset_rd_ff", cpu_rdata, 16'h00FF);
      drive(16'hFF0F, 0, 0);
      check("reset_ie", cpu_rdata, 16'h0000);
      drive(16'hFF46, 0, 0);
      check("reset_if", cpu_rdata, 16'h00E0);
      drive(16'h0000, 0, 0);
      check("reset_dma_reg", cpu_rdata, 16'h00FF);
      drive(16'hFF80, 8'h5A, 1);
      drive(16'hFF80, 0, 0);
      drive(16'hC000, 8'h33, 1);
      check("hram_rdback", cpu_rdata, 16'h005A);
      check("ext_write", ext_write, 1);
      check("ext_addr", ext_addr, 16'hC000);
      check("ext_wdata", ext_wdata, 16'h0033);
      drive(16'hFFFF, 8'h04, 1);
      drive(16'h0000, 0, 0, 5'h04, 0);
      check("pending_before", irq_pending, 0);
      drive(16'h0000, 0, 0);
      check("pending_after_req", irq_pending, 1);
      drive(16'h0000, 0, 0, 5'h04, 5'h04);
      drive(16'hFF0F, 0, 0);
      check("req_beats_clr", irq_pending, 1);
      drive(16'h0000, 0, 0, 0, 5'h04);
      check("if_read", cpu_rdata, 16'h00E4);
      drive(16'h0000, 0, 0);
      check("pending_cleared", irq_pending, 0);

      for (int i = 0; i < 127; i++) begin
         d = 8'($urandom);
         m_hram[i] = d;
         drive(16'hFF80 + 16'(i), d, 1);
      end
      m_ie = 8'h04;
      m_if = 0;
      have_exp = 0;
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 4);
         a = kind <= 1 ? 16'hFF80 + 16'($urandom_range(0, 126)) : kind == 2 ? 16'hFFFF :
             kind == 3 ? 16'hFF0F : 16'($urandom_range(0, 16'hFEFF));
         w = 1'($urandom);
         d = 8'($urandom);
         rq = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'h00;
         cl = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'h00;
         drive(a, d, w, rq, cl);
         if (have_exp) check("rnd_rdata", cpu_rdata, {8'h00, exp_rd});
         check("rnd_pending", irq_pending, |(m_ie[4:0] & m_if));
         check("rnd_ext_write", ext_write, w && kind == 4);
         if (kind == 4) check("rnd_ext_addr", ext_addr, a);
         exp_rd = kind <= 1 ? m_hram[a[6:0]] : kind == 2 ? m_ie : kind == 3 ? {3'b111, m_if} : a[7:0] ^ 8'hA5;
         have_exp = 1;
         if (w && kind <= 1) m_hram[a[6:0]] = d;
         if (w && kind == 2) m_ie = d;
         if (w && kind == 3) m_if = d[4:0];
         m_if = (m_if & ~cl) | rq;
      end

      drive(16'h0000, 0, 0);
      oam_q.delete();
      act_n = 0;
      drive(16'hFF46, 8'hC1, 1);
      for (int i = 0; i < 160; i++) begin
         a = i == 10 ? 16'h4000 : i == 20 ? 16'hD000 : i == 30 || i == 31 ? 16'hFF90 : 16'h0000;
         drive(a, 8'h77, i == 20 || i == 30);
         check("dma_ext_addr", ext_addr, {8'hC1, 8'(i)});
         check("dma_active", dma_active, 1);
         check("dma_no_ext_write", ext_write, 0);
         if (i == 11) check("dma_ext_read_ff", cpu_rdata, 16'h00FF);
         if (i == 32) check("dma_hram_rd", cpu_rdata, 16'h0077);
      end
      drive(16'h0000, 0, 0);
      check("dma_tail_active", dma_active, 1);
      check("dma_tail_oam", {oam_write, oam_addr}, 16'h019F);
      drive(16'hFF46, 0, 0);
      check("dma_done", dma_active, 0);
      drive(16'h0000, 0, 0);
      check("dma_reg_rd", cpu_rdata, 16'h00C1);
      check("dma_act_cycles", 16'(act_n), 16'd161);
      check("dma_oam_count", 16'(oam_q.size()), 16'd160);
      for (int i = 0; i < 160 && i < oam_q.size(); i++)
         check("dma_oam_entry", oam_q[i], {8'(i), 8'(i) ^ 8'hA5});

      oam_q.delete();
      act_n = 0;
      exp_q.delete();
      for (int i = 0; i < 50; i++) exp_q.push_back({8'(i), 8'(i) ^ 8'hA5});
      for (int j = 0; j < 80; j++) exp_q.push_back({8'(j), 8'(j) ^ 8'hA5});
      drive(16'hFF46, 8'hC1, 1);
      for (int i = 0; i < 50; i++) begin
         drive(i == 49 ? 16'hFF46 : 16'h0000, 8'hD2, i == 49);
         check("rs_ext_addr_old", ext_addr, {8'hC1, 8'(i)});
      end
      for (int j = 0; j < 80; j++) begin
         drive(16'h0000, 0, 0);
         check("rs_ext_addr_new", ext_addr, {8'hD2, 8'(j)});
         check("rs_active", dma_active, 1);
         if (j == 0) check("rs_inflight_oam", {oam_write, oam_addr}, 16'h0131);
      end
      @(posedge clk);
      #1;
      reset = 1;
      cpu_write = 0;
      @(negedge clk);
      check("rs_pre_reset_addr", ext_addr, 16'hD250);
      drive(16'h0000, 0, 0);
      check("rst_abort_active", dma_active, 0);
      check("rst_abort_oam", oam_write, 0);
      drive(16'h0000, 0, 0);
      check("rs_act_cycles", 16'(act_n), 16'd131);
      check("rs_oam_count", 16'(oam_q.size()), 16'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < oam_q.size(); i++)
         check("rs_oam_entry", oam_q[i], exp_q[i]);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/gb_bus_responder.md
# gb_bus_responder

Responder side of the sm83 core's memory bus. It decodes every `addr`/`write` cycle the core initiates and returns read data on the core's `d_in`. It serves HRAM, IE, IF and the OAM DMA register internally, and forwards all other addresses to an external synchronous memory port. It also contains the OAM DMA engine, which owns the external port while a transfer runs, and it produces the interrupt-pending flag for the core.

## Interface
Parameters:
- `DMA_LEN`, default 160: bytes per OAM DMA transfer.
- `IRQ_N`, default 5: number of interrupt sources (bits of IE/IF in use).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_addr`  in  16  address from core (`addr`).
- `cpu_wdata`  in  8  write data from core (`d_out`).
- `cpu_write`  in  1  core write strobe.
- `cpu_rdata`  out  8  read data to core (`d_in`).
- `ext_addr`  out  16  external memory address.
- `ext_wdata`  out  8  external write data.
- `ext_write`  out  1  external write strobe.
- `ext_rdata`  in  8  external read data, valid 1 cycle after `ext_addr`.
- `oam_addr`  out  8  OAM write address (DMA only).
- `oam_wdata`  out  8  OAM write data.
- `oam_write`  out  1  OAM write strobe.
- `irq_req`  in  IRQ_N  interrupt request pulses; set IF bits.
- `irq_clr`  in  IRQ_N  clear IF bits on core dispatch.
- `irq_pending`  out  1  |(IE & IF).
- `dma_active`  out  1  DMA transfer in progress.

## Operation
- Address map:
  - 0xFF0F is IF: bits [IRQ_N-1:0]; unused bits read 1.
  - 0xFF46 is DMA: write starts a transfer; read returns the last value written.
  - 0xFF80–0xFFFE is HRAM: 127 bytes, internal.
  - 0xFFFF is IE: 8 bits, all readable and writable.
  - All other addresses are external.
- Writes: committed on the rising edge where `cpu_write`=1, using `cpu_addr` and `cpu_wdata` at that edge.
- External pass-through when not in DMA: `ext_addr`=`cpu_addr`, `ext_wdata`=`cpu_wdata`, `ext_write`=`cpu_write` & external-region (combinational).
- Read path:
  - A source-select register captures the region of `cpu_addr` each edge.
  - An internal read register captures HRAM/IE/IF/DMA data each edge.
  - `cpu_rdata` = `ext_rdata` when the selected source is external, else the internal read register.
- IF update priority (lowest to highest): current value, then CPU write, then `irq_clr` clears, then `irq_req` sets. A request therefore wins over a simultaneous clear or write-zero of the same bit.
- DMA state machine: IDLE → RUN → IDLE.
  - A write to 0xFF46 with value V loads src_hi=V, sets cnt=0 and enters RUN. This happens from any state, so a write during RUN restarts at cnt=0 with the new V.
  - In RUN, each cycle drives `ext_addr`={V,cnt}, `ext_write`=0, then increments cnt.
  - A one-deep pipeline stage writes the previous cycle's `ext_rdata` to OAM at the previous cnt: `oam_write`=1, `oam_addr`=previous cnt.
  - After issuing cnt=DMA_LEN-1, the engine returns to IDLE. The final OAM write occurs on the cycle after.
  - On a restart, the pipeline's in-flight byte is still written; it carries the old cnt.
- Core access during RUN:
  - HRAM, IE, IF and 0xFF46 behave normally.
  - External-region reads return 0xFF. External writes are dropped: `ext_write` is never asserted by the core during RUN.
- Source pages V ≥ 0xE0 are not remapped; the transfer reads `ext_addr`={V,cnt} as-is.

## Timing
- Reset values:
  - IE=0x00, IF=0 (reads 0xE0), DMA reg=0xFF, state=IDLE, cnt=0.
  - `dma_active`=0, `oam_write`=0, `ext_write` follows pass-through (0 unless `cpu_write`).
  - Source-select=internal, internal read register=0xFF, so `cpu_rdata`=0xFF.
  - HRAM contents undefined.
- Read latency: 1 cycle. Data for the address at edge n appears on `cpu_rdata` during cycle n+1.
- A write followed by a read of the same internal address on the next cycle returns the new value.
- `dma_active`=1 from the cycle after the 0xFF46 write through the final OAM write, inclusive. That is DMA_LEN+1 cycles.
- `irq_pending` is combinational from the IE/IF registers and reflects a request one cycle after `irq_req`.
- Reset during RUN aborts immediately: no further `oam_write`, `dma_active`=0 on the next cycle.

## Test plan
- Reset, then read 0xFFFF, 0xFF0F and 0xFF46 on consecutive cycles → `cpu_rdata` shows 0x00, 0xE0 and 0xFF, each one cycle after its address.
- Write 0x5A to 0xFF80, read it back on the next cycle → 0x5A. Write 0x33 to 0xC000 → `ext_write`=1, `ext_addr`=0xC000, `ext_wdata`=0x33.
- Set IE=0x04, pulse `irq_req`=0x04 → `irq_pending`=1 next cycle. Assert `irq_clr`=0x04 and `irq_req`=0x04 together → IF bit 2 stays 1. Assert `irq_clr` alone → bit clears and `irq_pending`=0.
- Write 0xC1 to 0xFF46 with the ext model returning low byte XOR 0xA5 → 160 OAM writes at addr 0..159 with data {i^0xA5}, `dma_active` high for 161 cycles, `ext_addr` sweeping 0xC100..0xC19F.
- During DMA, core reads 0x4000 → 0xFF; core writes 0xD000 → no `ext_write`; core reads/writes HRAM 0xFF90 → normal behaviour.
- Restart to 0xD2 at cnt=50 → one more OAM write at addr 49, then a fresh sweep from 0xD200 with `dma_active` held high. Assert reset at cnt=80 → `oam_write` drops and `dma_active`=0 the next cycle.
